// File: rtl/ttc_counter_evgen14.sv
// ttc_counter_evgen14: single-channel TTC timer/counter producing interval, match, overflow and restart pulses.
// Ports: pclk14/n_p_reset14 (clock, sync active-low reset); pwdata14 + *_reg_sel14 (APB register writes);
//        counter_val_out14, cntr_ctrl_reg_out14, clk_ctrl_reg_out14 (readback);
//        interval_intr14, match_intr14[3:1], overflow_intr14, restart14 (one-cycle event pulses).
module ttc_counter_evgen14 (
    input  logic        pclk14,
    input  logic        n_p_reset14,
    input  logic [15:0] pwdata14,
    input  logic        clk_ctrl_reg_sel14,
    input  logic        cntr_ctrl_reg_sel14,
    input  logic        interval_reg_sel14,
    input  logic        match_1_reg_sel14,
    input  logic        match_2_reg_sel14,
    input  logic        match_3_reg_sel14,
    output logic [15:0] counter_val_out14,
    output logic [5:0]  cntr_ctrl_reg_out14,
    output logic [4:0]  clk_ctrl_reg_out14,
    output logic        interval_intr14,
    output logic [3:1]  match_intr14,
    output logic        overflow_intr14,
    output logic        restart14
);
    logic [15:0] interval, match_1, match_2, match_3, prescaler;
    logic [15:0] ps_lim, next_cnt, start_val;
    logic        tick, ivl_hit, wrap, restart, down, ivl_mode;
    always_comb begin
        down      = cntr_ctrl_reg_out14[2];
        ivl_mode  = cntr_ctrl_reg_out14[1];
        // 2^(N+1)-1 for N in 0..15
        ps_lim    = 16'hFFFF >> (4'd15 - clk_ctrl_reg_out14[4:1]);
        tick      = !cntr_ctrl_reg_out14[0] && (!clk_ctrl_reg_out14[0] || prescaler == ps_lim);
        ivl_hit   = ivl_mode && (down ? counter_val_out14 == 16'h0000 : counter_val_out14 == interval);
        wrap      = !ivl_mode && (down ? counter_val_out14 == 16'h0000 : counter_val_out14 == 16'hFFFF);
        next_cnt  = ivl_hit ? (down ? interval : 16'h0000)
                  : down ? counter_val_out14 - 16'd1 : counter_val_out14 + 16'd1;
        restart   = cntr_ctrl_reg_sel14 && pwdata14[4];
        // start value follows the mode bits being written, not the stored ones
        start_val = !pwdata14[2] ? 16'h0000 : pwdata14[1] ? interval : 16'hFFFF;
    end
    always_ff @(posedge pclk14) begin
        if (!n_p_reset14) begin
            cntr_ctrl_reg_out14 <= 6'h01;
            clk_ctrl_reg_out14  <= 5'h00;
            interval            <= 16'hFFFF;
            match_1             <= 16'h0000;
            match_2             <= 16'h0000;
            match_3             <= 16'h0000;
            counter_val_out14   <= 16'h0000;
            prescaler           <= 16'h0000;
            interval_intr14     <= 1'b0;
            match_intr14        <= 3'b000;
            overflow_intr14     <= 1'b0;
            restart14           <= 1'b0;
        end else begin
            interval_intr14 <= 1'b0;
            match_intr14    <= 3'b000;
            overflow_intr14 <= 1'b0;
            restart14       <= 1'b0;
            if (clk_ctrl_reg_sel14)  clk_ctrl_reg_out14  <= pwdata14[4:0];
            if (cntr_ctrl_reg_sel14) cntr_ctrl_reg_out14 <= {2'b00, pwdata14[3:0]};
            if (interval_reg_sel14)  interval            <= pwdata14;
            if (match_1_reg_sel14)   match_1             <= pwdata14;
            if (match_2_reg_sel14)   match_2             <= pwdata14;
            if (match_3_reg_sel14)   match_3             <= pwdata14;
            if (restart) begin
                // restart wins over a coincident tick; that tick is dropped
                counter_val_out14 <= start_val;
                prescaler         <= 16'h0000;
                restart14         <= 1'b1;
            end else if (!cntr_ctrl_reg_out14[0]) begin
                prescaler <= (clk_ctrl_reg_out14[0] && !tick) ? prescaler + 16'd1 : 16'h0000;
                if (tick) begin
                    counter_val_out14 <= next_cnt;
                    interval_intr14   <= ivl_hit;
                    overflow_intr14   <= wrap;
                    match_intr14      <= {3{cntr_ctrl_reg_out14[3]}}
                                       & {next_cnt == match_3, next_cnt == match_2, next_cnt == match_1};
                end
            end
        end
    end
endmodule

// File: tb/tb_ttc_counter_evgen14.sv
// tb_ttc_counter_evgen14: vector table plus randomized writes checked against a behavioural model.
module tb_ttc_counter_evgen14;
    logic        pclk14 = 1'b0;
    logic        n_p_reset14;
    logic [15:0] pwdata14;
    logic        clk_ctrl_reg_sel14, cntr_ctrl_reg_sel14, interval_reg_sel14;
    logic        match_1_reg_sel14, match_2_reg_sel14, match_3_reg_sel14;
    logic [15:0] counter_val_out14;
    logic [5:0]  cntr_ctrl_reg_out14;
    logic [4:0]  clk_ctrl_reg_out14;
    logic        interval_intr14, overflow_intr14, restart14;
    logic [3:1]  match_intr14;

    ttc_counter_evgen14 dut (
        .pclk14(pclk14), .n_p_reset14(n_p_reset14), .pwdata14(pwdata14),
        .clk_ctrl_reg_sel14(clk_ctrl_reg_sel14), .cntr_ctrl_reg_sel14(cntr_ctrl_reg_sel14),
        .interval_reg_sel14(interval_reg_sel14), .match_1_reg_sel14(match_1_reg_sel14),
        .match_2_reg_sel14(match_2_reg_sel14), .match_3_reg_sel14(match_3_reg_sel14),
        .counter_val_out14(counter_val_out14), .cntr_ctrl_reg_out14(cntr_ctrl_reg_out14),
        .clk_ctrl_reg_out14(clk_ctrl_reg_out14), .interval_intr14(interval_intr14),
        .match_intr14(match_intr14), .overflow_intr14(overflow_intr14), .restart14(restart14)
    );

    always #5 pclk14 = ~pclk14;

    localparam logic [5:0] S_CLK = 6'h01, S_CC = 6'h02, S_IV = 6'h04, S_M1 = 6'h08, S_M2 = 6'h10, S_M3 = 6'h20;
    localparam logic [5:0] P_RS = 6'h20, P_OV = 6'h10, P_IV = 6'h08;

    typedef struct {
        logic        rstn;
        logic [5:0]  sel;
        logic [15:0] d;
        logic [15:0] cnt;
        logic [5:0]  pul;
        logic [5:0]  cc;
    } vec_t;
    vec_t tbl[$];

    int tests = 0, fails = 0;

    // behavioural model state
    int m_cnt, m_ivl, m_ps, m_cc, m_ck;
    int m_m[1:3];
    logic e_rs, e_ov, e_iv;
    logic [3:1] e_match;

    function automatic logic [5:0] dut_pulses();
        return {restart14, overflow_intr14, interval_intr14, match_intr14};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic rstn, input logic [5:0] sel, input logic [15:0] d);
        int nxt, period;
        bit tk;
        e_rs = 0; e_ov = 0; e_iv = 0; e_match = 3'b000;
        if (!rstn) begin
            m_cnt = 0; m_ivl = 65535; m_ps = 0; m_cc = 1; m_ck = 0;
            m_m[1] = 0; m_m[2] = 0; m_m[3] = 0;
            return;
        end
        if (sel[1] && d[4]) begin
            e_rs = 1; m_ps = 0;
            m_cnt = !d[2] ? 0 : d[1] ? m_ivl : 65535;
        end else if ((m_cc & 1) == 0) begin
            if ((m_ck & 1) != 0) begin
                period = 1 << ((m_ck >> 1) + 1);
                tk = (m_ps == period - 1);
                m_ps = tk ? 0 : (m_ps + 1) % 65536;
            end else begin
                tk = 1; m_ps = 0;
            end
            if (tk) begin
                if ((m_cc & 2) != 0) begin
                    if ((m_cc & 4) == 0) begin
                        e_iv = (m_cnt == m_ivl);
                        nxt = e_iv ? 0 : (m_cnt + 1) % 65536;
                    end else begin
                        e_iv = (m_cnt == 0);
                        nxt = e_iv ? m_ivl : m_cnt - 1;
                    end
                end else begin
                    nxt = ((m_cc & 4) == 0) ? (m_cnt + 1) % 65536 : (m_cnt + 65535) % 65536;
                    e_ov = ((m_cc & 4) == 0) ? (nxt == 0) : (nxt == 65535);
                end
                if ((m_cc & 8) != 0)
                    for (int n = 1; n <= 3; n++) e_match[n] = (nxt == m_m[n]);
                m_cnt = nxt;
            end
        end
        if (sel[0]) m_ck = d & 16'h1F;
        if (sel[1]) m_cc = d & 16'h0F;
        if (sel[2]) m_ivl = d;
        if (sel[3]) m_m[1] = d;
        if (sel[4]) m_m[2] = d;
        if (sel[5]) m_m[3] = d;
    endtask

    task automatic apply(input logic rstn, input logic [5:0] sel, input logic [15:0] d);
        int mc;
        n_p_reset14 = rstn;
        {match_3_reg_sel14, match_2_reg_sel14, match_1_reg_sel14,
         interval_reg_sel14, cntr_ctrl_reg_sel14, clk_ctrl_reg_sel14} = sel;
        pwdata14 = d;
        @(posedge pclk14);
        model(rstn, sel, d);
        #1;
        mc = m_cnt;
        chk("model_count", counter_val_out14, mc[15:0]);
        chk("model_pulses", dut_pulses(), {e_rs, e_ov, e_iv, e_match});
        chk("model_cntr_ctrl", cntr_ctrl_reg_out14, m_cc[5:0]);
        chk("model_clk_ctrl", clk_ctrl_reg_out14, m_ck[4:0]);
        n_p_reset14 = 1'b1;
        {match_3_reg_sel14, match_2_reg_sel14, match_1_reg_sel14,
         interval_reg_sel14, cntr_ctrl_reg_sel14, clk_ctrl_reg_sel14} = 6'h00;
        pwdata14 = 16'h0000;
    endtask

    task automatic add(input logic rstn, input logic [5:0] sel, input logic [15:0] d,
                       input logic [15:0] cnt, input logic [5:0] pul, input logic [5:0] cc);
        vec_t v;
        v.rstn = rstn; v.sel = sel; v.d = d; v.cnt = cnt; v.pul = pul; v.cc = cc;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] d;
        int r, w;
        n_p_reset14 = 1'b0;
        pwdata14 = 16'h0000;
        {match_3_reg_sel14, match_2_reg_sel14, match_1_reg_sel14,
         interval_reg_sel14, cntr_ctrl_reg_sel14, clk_ctrl_reg_sel14} = 6'h00;
        apply(1'b0, 6'h00, 16'h0000);

        // reset, then down free-run underflow
        add(0, 0, 0, 16'h0000, 0, 6'h01);
        add(1, S_CC, 16'h0004, 16'h0000, 0, 6'h04);
        add(1, 0, 0, 16'hFFFF, P_OV, 6'h04);
        add(1, 0, 0, 16'hFFFE, 0, 6'h04);
        // reset while running, counter stays put while disabled
        add(0, 0, 0, 16'h0000, 0, 6'h01);
        add(1, 0, 0, 16'h0000, 0, 6'h01);
        // up interval = 5
        add(1, S_IV, 16'd5, 16'h0000, 0, 6'h01);
        add(1, S_CC, 16'h0002, 16'h0000, 0, 6'h02);
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 16'(i), 0, 6'h02);
        add(1, 0, 0, 16'h0000, P_IV, 6'h02);
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 16'(i), 0, 6'h02);
        // restart lands on the tick that would have hit the interval
        add(1, S_CC, 16'h0012, 16'h0000, P_RS, 6'h02);
        add(1, 0, 0, 16'h0001, 0, 6'h02);
        // match 1/3 = 3, match 2 = 7, interval 9 (match 1 and 3 written together)
        add(0, 0, 0, 16'h0000, 0, 6'h01);
        add(1, S_M1 | S_M3, 16'd3, 16'h0000, 0, 6'h01);
        add(1, S_M2, 16'd7, 16'h0000, 0, 6'h01);
        add(1, S_IV, 16'd9, 16'h0000, 0, 6'h01);
        add(1, S_CC, 16'h000A, 16'h0000, 0, 6'h0A);
        for (int k = 1; k <= 13; k++)
            add(1, 0, 0, 16'(k % 10), (k % 10 == 3) ? 6'h05 : (k % 10 == 7) ? 6'h02 : (k % 10 == 0) ? P_IV : 6'h00, 6'h0A);
        // prescaler N = 1: one tick per 4 clocks
        add(0, 0, 0, 16'h0000, 0, 6'h01);
        add(1, S_CLK, 16'h0003, 16'h0000, 0, 6'h01);
        add(1, S_CC, 16'h0000, 16'h0000, 0, 6'h00);
        for (int k = 0; k < 12; k++) add(1, 0, 0, 16'((k + 1) / 4), 0, 6'h00);

        foreach (tbl[i]) begin
            apply(tbl[i].rstn, tbl[i].sel, tbl[i].d);
            chk($sformatf("vec%0d_count", i), counter_val_out14, tbl[i].cnt);
            chk($sformatf("vec%0d_pulses", i), dut_pulses(), tbl[i].pul);
            chk($sformatf("vec%0d_cntr_ctrl", i), cntr_ctrl_reg_out14, tbl[i].cc);
        end
        chk("clk_ctrl_readback", clk_ctrl_reg_out14, 5'h03);

        // interval = 0: stuck at 0, interval pulse on every tick
        apply(0, 0, 0);
        apply(1, S_IV, 16'h0000);
        apply(1, S_CC, 16'h0002);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0);
            chk("ivl0_count", counter_val_out14, 16'h0000);
            chk("ivl0_pulse", interval_intr14, 1'b1);
        end
        // restart together with disable, down free-run
        apply(1, S_CC, 16'h0015);
        chk("rst_dis_count", counter_val_out14, 16'hFFFF);
        chk("rst_dis_pulse", restart14, 1'b1);
        chk("rst_dis_ctrl", cntr_ctrl_reg_out14, 6'h05);
        apply(1, 0, 0);
        chk("rst_dis_hold", counter_val_out14, 16'hFFFF);
        chk("rst_dis_once", restart14, 1'b0);

        // randomized one-register-at-a-time writes against the model
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            d = 16'($urandom);
            if (r < 1) apply(0, 0, 0);
            else if (r < 75) apply(1, 0, 0);
            else begin
                w = $urandom_range(0, 5);
                case (w)
                    0: begin d[4:1] = 4'($urandom_range(0, 2)); end
                    1: begin if ($urandom_range(0, 3) != 0) d[0] = 1'b0; if ($urandom_range(0, 2) != 0) d[4] = 1'b0; end
                    default: if ($urandom_range(0, 9) != 0) d = 16'($urandom_range(0, 20));
                endcase
                apply(1, 6'(1 << w), d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
